pixel_stream_source: RTL

Upstream pixel source for the HDMI path: accepts RGB pixels from a producer over a valid/ready stream, buffers them in a FIFO, and releases one pixel per active video cycle aligned to the blank/hsync/vsync timing from the sync generator. Its registered RGB and sync outputs drive the video encoder directly. It detects underflow and frame misalignment, then resynchronises at the next frame boundary.

---
 rtl/pixel_stream_source.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/pixel_stream_source.sv
// pixel_stream_source
//
// Pixel source for the HDMI path. RGB pixels arrive from a producer over a
// valid/ready stream and are buffered in a small FIFO. One pixel is
// released per active video cycle, aligned to the blank/hsync/vsync timing
// from the sync generator. All video outputs are registered so they can
// drive the encoder directly, one cycle behind the sync inputs.
//
// Underflow (FIFO empty mid-frame) and frame misalignment (SOF not at the
// frame start) are flagged sticky. In both cases the block shows FILL_RGB
// and resynchronises at the next frame boundary.
//
// Parameters
//   DEPTH     FIFO depth in pixels (power of two, at least 4)
//   FILL_RGB  colour shown on active cycles that have no valid pixel
//
// Ports
//   clk, reset_n               pixel clock, async active-low reset
//   s_valid, s_ready, s_data,  producer stream; s_sof marks pixel 0 of a
//   s_sof                      frame; s_ready = !full
//   blank, hsync, vsync        timing-generator inputs
//   err_clr                    clears the sticky error flags
//   blank_o, hsync_o, vsync_o  sync inputs delayed by one cycle
//   red, green, blue           pixel data aligned to blank_o
//   underflow, sof_err         sticky error flags
//   level                      FIFO occupancy
module pixel_stream_source #(
  parameter int          DEPTH    = 16,
  parameter logic [23:0] FILL_RGB = 24'hFF00FF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [23:0]              s_data,
  input  logic                     s_sof,
  input  logic                     blank,
  input  logic                     hsync,
  input  logic                     vsync,
  input  logic                     err_clr,
  output logic                     blank_o,
  output logic                     hsync_o,
  output logic                     vsync_o,
  output logic [7:0]               red,
  output logic [7:0]               green,
  output logic [7:0]               blue,
  output logic                     underflow,
  output logic                     sof_err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_LEVEL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    SEEK,
    WAIT,
    ACTIVE
  } state_t;

  typedef struct packed {
    logic        sof;
    logic [23:0] rgb;
  } entry_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  entry_t          head;

  // Ready depends only on registered occupancy, so a full FIFO refuses a
  // push even when the FSM pops in the same cycle.
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign s_ready = !full;
  assign push    = s_valid && !full;
  assign head    = mem[rd_ptr];

  // NOTE: the pixel storage has no reset; stale entries are unreachable
  // because the pointers and level are reset, and skipping the reset lets
  // the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{sof: s_sof, rgb: s_data};
    end
  end

  // NOTE: every register below is assigned with <= so all state updates
  // on an edge see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame start detection: armed by vsync, fired on the first active cycle
  // ---------------------------------------------------------------------------
  logic frame_arm;
  logic frame_start;

  assign frame_start = !blank && frame_arm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_arm <= 1'b0;
    end else if (vsync) begin
      frame_arm <= 1'b1;
    end else if (!blank) begin
      frame_arm <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Alignment FSM
  // ---------------------------------------------------------------------------
  state_t        state;
  state_t        state_next;
  logic [23:0]   pix;
  logic          set_underflow;
  logic          set_sof_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEEK;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: all outputs of this block get a default before the case so no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next    = state;
    pop           = 1'b0;
    pix           = FILL_RGB;
    set_underflow = 1'b0;
    set_sof_err   = 1'b0;
    case (state)
      // Drop pixels until the head of the FIFO is a frame start.
      SEEK: begin
        if (!empty) begin
          if (head.sof) begin
            state_next = WAIT;
          end else begin
            pop = 1'b1;
          end
        end
      end
      // Hold the SOF pixel until the display reaches its frame start.
      WAIT: begin
        if (frame_start && !empty && head.sof) begin
          pop        = 1'b1;
          pix        = head.rgb;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!blank) begin
          if (empty) begin
            set_underflow = 1'b1;
            state_next    = SEEK;
          end else if (head.sof) begin
            if (frame_start) begin
              pop = 1'b1;
              pix = head.rgb;
            end else begin
              // Producer frame ended early; keep its SOF for the next frame.
              set_sof_err = 1'b1;
              state_next  = WAIT;
            end
          end else begin
            if (frame_start) begin
              // Producer frame is longer than the display frame.
              set_sof_err = 1'b1;
              state_next  = SEEK;
            end else begin
              pop = 1'b1;
              pix = head.rgb;
            end
          end
        end
      end
      default: state_next = SEEK;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered video outputs and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_o <= 1'b1;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
      red     <= '0;
      green   <= '0;
      blue    <= '0;
    end else begin
      blank_o <= blank;
      hsync_o <= hsync;
      vsync_o <= vsync;
      {red, green, blue} <= blank ? 24'h000000 : pix;
    end
  end

  // A set event in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      if (set_underflow)  underflow <= 1'b1;
      else if (err_clr)   underflow <= 1'b0;
      if (set_sof_err)    sof_err   <= 1'b1;
      else if (err_clr)   sof_err   <= 1'b0;
    end
  end

endmodule
